// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and state encoding for the FIR MAC sequencer
package fir_pkg;

  localparam int N_TAPS_DEF = 8;
  localparam int ADDR_W_DEF = $clog2(N_TAPS_DEF);

  // Cycles between presenting a tap address and its product reaching the accumulator
  localparam int MAC_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MAC,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - strobe inputs and datapath controls of the FIR MAC sequencer
interface fir_mac_sequencer_if #(
  parameter int ADDR_W = fir_pkg::ADDR_W_DEF
);

  logic              enable;
  logic              sample_valid;
  logic              shift_en;
  logic [ADDR_W-1:0] tap_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              result_valid;
  logic              busy;
  logic              overrun;

  modport master (
    input  enable, sample_valid,
    output shift_en, tap_addr, acc_clr, acc_en, result_valid, busy, overrun
  );

  modport slave (
    output enable, sample_valid,
    input  shift_en, tap_addr, acc_clr, acc_en, result_valid, busy, overrun
  );

endinterface

// File: rtl/tap_down_counter.sv
// rtl/tap_down_counter.sv - tap address down-counter that saturates at zero and reloads to N_TAPS-1
module tap_down_counter #(
  parameter int N_TAPS = fir_pkg::N_TAPS_DEF,
  parameter int ADDR_W = fir_pkg::ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              dec_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              zero_o
);

  localparam logic [ADDR_W-1:0] LOAD_VAL = ADDR_W'(N_TAPS - 1);

  logic [ADDR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= LOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - control FSM for the serial FIR: shift, tap walk, accumulate, flag result
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  fir_mac_sequencer_if.master bus
);

  state_e            state_q, state_d;
  logic              accept;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [ADDR_W-1:0] tap_addr_w;
  logic              acc_en_w;
  logic              shift_en_q, acc_clr_q, result_valid_q, busy_q, overrun_q;

  tap_down_counter #(
    .N_TAPS (N_TAPS),
    .ADDR_W (ADDR_W)
  ) u_tap_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cnt_load),
    .dec_i   (cnt_dec),
    .count_o (tap_addr_w),
    .zero_o  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    accept   = bus.sample_valid && bus.enable;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_MAC;
      ST_MAC: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        cnt_load = 1'b1;
        state_d  = accept ? ST_SHIFT : ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so every output comes straight off a flop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      shift_en_q     <= 1'b0;
      acc_clr_q      <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_en_q     <= (state_d == ST_SHIFT);
      acc_clr_q      <= (state_d == ST_SHIFT);
      result_valid_q <= (state_d == ST_DONE);
      busy_q         <= (state_d inside {ST_SHIFT, ST_MAC, ST_DRAIN});
      overrun_q      <= bus.sample_valid && busy_q;
    end
  end

  // acc_en trails the MAC window by the ROM/multiplier latency
  if (MAC_LAT == 1) begin : g_lat_one
    logic pipe_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) pipe_q <= 1'b0;
      else        pipe_q <= (state_q == ST_MAC);
    end
    assign acc_en_w = pipe_q;
  end else begin : g_lat_n
    logic [MAC_LAT-1:0] pipe_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) pipe_q <= '0;
      else        pipe_q <= {pipe_q[MAC_LAT-2:0], (state_q == ST_MAC)};
    end
    assign acc_en_w = pipe_q[MAC_LAT-1];
  end

  assign bus.shift_en     = shift_en_q;
  assign bus.tap_addr     = tap_addr_w;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.acc_en       = acc_en_w;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - self-checking bench for fir_mac_sequencer with a schedule model and datapath model
module tb_fir_mac_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(.ADDR_W(AW)) bus();

  fir_mac_sequencer #(.N_TAPS(N), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath stand-in: delay line, unit coefficients, registered product, accumulator
  int dl [N];
  int coef [N];
  int prod_q, acc_q, x_in;
  initial for (int i = 0; i < N; i++) coef[i] = 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) dl[i] <= 0;
      prod_q <= 0;
      acc_q  <= 0;
    end else begin
      if (bus.shift_en) begin
        dl[0] <= x_in;
        for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
      end
      prod_q <= dl[bus.tap_addr] * coef[bus.tap_addr];
      if (bus.acc_clr)     acc_q <= 0;
      else if (bus.acc_en) acc_q <= acc_q + prod_q;
    end
  end

  // Schedule model: every output is a fixed offset from the cycle a strobe was accepted
  bit m_active = 1'b0;
  int m_t0 = 0;
  bit m_ovr_next = 1'b0;
  int rv_count = 0;
  int ov_count = 0;
  int rv_cycles [$];
  int last_acc = 0;

  always @(negedge clk) begin : cmp
    int k, s, e_tap;
    bit e_shift, e_busy, e_acc, e_rv;
    if (!reset) begin
      check("rst_tap", int'(bus.tap_addr), N - 1);
      check("rst_shift", int'(bus.shift_en), 0);
      check("rst_clr", int'(bus.acc_clr), 0);
      check("rst_acc_en", int'(bus.acc_en), 0);
      check("rst_rv", int'(bus.result_valid), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_ovr", int'(bus.overrun), 0);
      m_active   = 1'b0;
      m_ovr_next = 1'b0;
    end else begin
      k       = cyc - m_t0;
      e_shift = m_active && (k == 1);
      e_busy  = m_active && (k >= 1) && (k <= N + 2);
      e_acc   = m_active && (k >= 3) && (k <= N + 2);
      e_rv    = m_active && (k == N + 3);
      if (m_active && (k >= 2) && (k <= N + 1)) e_tap = N + 1 - k;
      else if (m_active && (k == N + 2))        e_tap = 0;
      else                                      e_tap = N - 1;
      check("shift_en", int'(bus.shift_en), int'(e_shift));
      check("acc_clr", int'(bus.acc_clr), int'(e_shift));
      check("busy", int'(bus.busy), int'(e_busy));
      check("acc_en", int'(bus.acc_en), int'(e_acc));
      check("result_valid", int'(bus.result_valid), int'(e_rv));
      check("overrun", int'(bus.overrun), int'(m_ovr_next));
      if (!(m_active && (k == N + 3))) check("tap_addr", int'(bus.tap_addr), e_tap);
      if (bus.result_valid) begin
        rv_count++;
        rv_cycles.push_back(cyc);
        s = 0;
        for (int i = 0; i < N; i++) s += dl[i];
        check("dp_sum", acc_q, s);
        last_acc = acc_q;
      end
      if (bus.overrun) ov_count++;
      m_ovr_next = bus.sample_valid && e_busy;
      if (bus.sample_valid && bus.enable && !e_busy) begin
        m_active = 1'b1;
        m_t0     = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe();
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  initial begin : stim
    logic [12:0] se_v, clr_v, busy_v, acc_v, rv_v;
    logic [23:0] taps;
    int rv0, ov0;
    bus.enable       = 1'b1;
    bus.sample_valid = 1'b0;
    x_in             = 0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    check("idle_tap", int'(bus.tap_addr), 7);
    check("idle_busy", int'(bus.busy), 0);

    // Single strobe: record the first 12 cycles after acceptance
    se_v = '0; clr_v = '0; busy_v = '0; acc_v = '0; rv_v = '0; taps = '0;
    x_in = 5;
    strobe();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      se_v[k]   = bus.shift_en;
      clr_v[k]  = bus.acc_clr;
      busy_v[k] = bus.busy;
      acc_v[k]  = bus.acc_en;
      rv_v[k]   = bus.result_valid;
      if (k >= 2 && k <= 9) taps = {taps[20:0], bus.tap_addr};
    end
    step();
    check("seq_shift", int'(se_v), 'h0002);
    check("seq_clr", int'(clr_v), 'h0002);
    check("seq_busy", int'(busy_v), 'h07FE);
    check("seq_acc_en", int'(acc_v), 'h07F8);
    check("seq_rv", int'(rv_v), 'h0800);
    check("seq_taps", int'(taps), 'o76543210);

    // Back-to-back samples 1..8 at minimum spacing through the datapath
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    rv0 = rv_count;
    ov0 = ov_count;
    rv_cycles.delete();
    for (int i = 1; i <= 8; i++) begin
      x_in = i;
      strobe();
      repeat (10) step();
    end
    repeat (3) step();
    check("b2b_rv_count", rv_count - rv0, 8);
    check("b2b_overrun", ov_count - ov0, 0);
    for (int i = 1; i < 8; i++) check("b2b_spacing", rv_cycles[i] - rv_cycles[i-1], 11);
    check("dp_final", last_acc, 36);

    // Strobe 5 cycles after the first is dropped with an overrun
    rv0 = rv_count;
    ov0 = ov_count;
    strobe();
    repeat (4) step();
    strobe();
    repeat (15) step();
    check("ovr_count", ov_count - ov0, 1);
    check("ovr_rv_count", rv_count - rv0, 1);

    // enable=0 in idle ignores the strobe; dropping enable mid-operation lets it finish
    rv0 = rv_count;
    ov0 = ov_count;
    bus.enable = 1'b0;
    strobe();
    repeat (3) step();
    check("dis_idle_rv", rv_count - rv0, 0);
    check("dis_idle_ovr", ov_count - ov0, 0);
    bus.enable = 1'b1;
    strobe();
    repeat (3) step();
    bus.enable = 1'b0;
    strobe();
    repeat (12) step();
    check("dis_mac_rv", rv_count - rv0, 1);
    check("dis_mac_ovr", ov_count - ov0, 1);
    bus.enable = 1'b1;

    // Asynchronous abort while tap_addr is 4
    strobe();
    repeat (4) step();
    check("abort_pre_tap", int'(bus.tap_addr), 4);
    #2;
    reset = 1'b0;
    #1;
    check("abort_tap", int'(bus.tap_addr), 7);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_acc_en", int'(bus.acc_en), 0);
    check("abort_shift", int'(bus.shift_en), 0);
    check("abort_clr", int'(bus.acc_clr), 0);
    check("abort_rv", int'(bus.result_valid), 0);
    check("abort_ovr", int'(bus.overrun), 0);
    repeat (2) step();
    reset = 1'b1;
    rv0 = rv_count;
    repeat (15) step();
    check("abort_no_rv", rv_count - rv0, 0);
    strobe();
    repeat (12) step();
    check("abort_next_rv", rv_count - rv0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control FSM for the serial 8-tap FIR audio filter. On each sample strobe it shifts the delay line, walks the tap address down from N_TAPS-1 to 0, and drives accumulator clear/enable with the coefficient/multiplier latency compensated. It then flags the finished output sample. It sits between the sample-rate strobe generator and the delay-line/coefficient ROM/MAC datapath.

## Interface
- N_TAPS, 8, number of filter taps (power of two, ≥2)
- ADDR_W, 3, tap address width, = log2(N_TAPS)
- clk  in  1  system clock, rising edge; frequency ≥ (N_TAPS+3)·fs
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- enable  in  1  when 0, new sample_valid strobes are ignored; an operation in progress completes
- sample_valid  in  1  one-clk strobe: new input sample present at delay-line input
- shift_en  out  1  one-cycle pulse: delay-line registers load/shift
- tap_addr  out  ADDR_W  tap select for delay-line mux and coefficient ROM
- acc_clr  out  1  one-cycle pulse: accumulator cleared to 0
- acc_en  out  1  accumulator adds current product
- result_valid  out  1  one-cycle pulse: accumulator holds the finished output sample
- busy  out  1  operation in progress
- overrun  out  1  one-cycle pulse: sample_valid arrived while busy; that sample is dropped

## Operation
- States: IDLE, SHIFT, MAC, DRAIN, DONE.
- IDLE: tap_addr = N_TAPS-1. sample_valid & enable → SHIFT.
- SHIFT (1 cycle): shift_en=1, acc_clr=1 → MAC.
- MAC (N_TAPS cycles): tap_addr presented N_TAPS-1, N_TAPS-2, …, 0, one per cycle. After the cycle with tap_addr=0 → DRAIN.
- DRAIN (1 cycle): tap_addr = 0 held; completes the last accumulate → DONE.
- DONE (1 cycle): result_valid=1; tap_addr reloads to N_TAPS-1. sample_valid & enable → SHIFT (back-to-back), else → IDLE.
- acc_en = "in MAC" registered one cycle. High from the 2nd MAC cycle through DRAIN, exactly N_TAPS cycles. Compensates the 1-cycle registered ROM/product latency.
- busy = 1 in SHIFT, MAC, DRAIN; 0 in IDLE and DONE.
- overrun pulses for any sample_valid while busy=1, regardless of enable. State is unaffected.
- sample_valid with enable=0 in IDLE/DONE: ignored, no overrun.
- tap_addr wraps never: the down-count stops at 0 and reloads only at DONE.

## Timing
- Reset values: tap_addr = N_TAPS-1; shift_en, acc_clr, acc_en, result_valid, busy, overrun = 0; state IDLE.
- Reset asserted mid-operation: all outputs take reset values immediately (async). No result_valid is issued for the aborted sample.
- Strobe accepted at cycle 0:
  - cycle 1: shift_en and acc_clr asserted.
  - cycles 2 … N_TAPS+1: tap_addr values.
  - cycles 3 … N_TAPS+2: acc_en asserted.
  - cycle N_TAPS+3: result_valid asserted (cycle 11 for N_TAPS=8).
- Minimum accepted strobe spacing: N_TAPS+3 cycles (a strobe in the DONE cycle is accepted). Closer strobes produce overrun.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Package fir_pkg: N_TAPS and ADDR_W defaults, state enumeration, latency constant MAC_LAT=1.
- Sub-module tap_down_counter:
  - Inputs: load, dec.
  - Output: count; reset/load value N_TAPS-1.
  - Flag: zero.
- The FSM drives load (at reset/DONE) and dec (in MAC) and uses zero for the MAC→DRAIN transition.

## Test plan
- Reset then single strobe at cycle 0 → shift_en and acc_clr at cycle 1; tap_addr 7,6,…,0 on cycles 2–9; acc_en on cycles 3–10; result_valid at cycle 11; busy high on cycles 1–10.
- Strobes every 11 cycles for 5 samples → 5 result_valid pulses 11 cycles apart, no overrun, no IDLE cycle between operations.
- Second strobe 5 cycles after the first → overrun pulse on that cycle; the first operation completes normally; only one result_valid.
- enable=0 with a strobe in IDLE → no state change, no overrun. enable dropped during MAC → the current sample still finishes with result_valid.
- reset asserted while tap_addr=4 → tap_addr=7 and all flags 0 asynchronously; after release, no result_valid; the next strobe runs a full normal sequence.
- Bench-level check with a datapath model, coefficients all 1 and input samples 1..8 → first complete output equals the sum of the delay-line contents.
